path_sequencer: RTL and testbench

Controller that sequences the arena navigation datapath. It accepts a planned node path from the CPU path planner over a valid/ready stream and stores it locally. It then steps through the path on each line-follower node detection. For each leg it resolves the required heading from the arena adjacency table and issues a relative turn command (straight/right/U-turn/left) to the motor controller. It also tracks the real-time position and heading.

---
 rtl/nav_pkg.sv | 52 +++++
 rtl/path_sequencer_if.sv | 33 +++
 rtl/node_adjacency_rom.sv | 53 +++++
 rtl/path_sequencer.sv | 175 +++++++++++++++++
 tb/tb_path_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nav_pkg.sv
// Purpose: shared arena-navigation types: node ids, directions, turn codes, sequencer states.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
`timescale 1ns/1ps
package nav_pkg;

    localparam int NODE_ID_W = 5;
    typedef logic [NODE_ID_W-1:0] node_id_t;

    // Neighbour set indexed by absolute direction (index 0 = north).
    typedef node_id_t [3:0] nbr_set_t;

    localparam node_id_t NODE_NONE = 5'd31;
    localparam node_id_t NUM_NODES = 5'd30;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        TURN_STRAIGHT = 2'd0,
        TURN_RIGHT    = 2'd1,
        TURN_UTURN    = 2'd2,
        TURN_LEFT     = 2'd3
    } turn_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_START,
        S_LOOKUP,
        S_TURN_OUT,
        S_WAIT_NODE,
        S_DONE,
        S_ERROR
    } seq_state_t;

    function automatic nbr_set_t mk_nbrs(node_id_t n, node_id_t e, node_id_t s, node_id_t w);
        return {w, s, e, n};
    endfunction

    // Relative turn is the clockwise quarter-turn count, wrapping mod 4.
    function automatic turn_t rel_turn(dir_t to_dir, dir_t from_dir);
        logic [1:0] diff;
        diff = 2'(to_dir) - 2'(from_dir);
        return turn_t'(diff);
    endfunction

endpackage

// File: rtl/path_sequencer_if.sv
// Purpose: bundles the path-load stream, traversal controls and navigation outputs.
// Latency: n/a (wiring only).
// Backpressure: path_valid/path_ready stream; all other signals are pulses or levels.
// Ports: master = CPU/line-follower side, slave = path_sequencer.
`timescale 1ns/1ps
interface path_sequencer_if #(
    parameter int NODE_W = 5
);
    logic              clear;
    logic              path_valid;
    logic [NODE_W-1:0] path_node;
    logic              path_last;
    logic              path_ready;
    logic              start;
    logic              node_flag;
    logic [1:0]        turn_flag;
    logic              turn_valid;
    logic [NODE_W-1:0] realtime_pos;
    logic [1:0]        heading;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output clear, path_valid, path_node, path_last, start, node_flag,
        input  path_ready, turn_flag, turn_valid, realtime_pos, heading, busy, done, error
    );

    modport slave (
        input  clear, path_valid, path_node, path_last, start, node_flag,
        output path_ready, turn_flag, turn_valid, realtime_pos, heading, busy, done, error
    );
endinterface

// File: rtl/node_adjacency_rom.sv
// Purpose: arena map, node id -> {N,E,S,W} neighbour ids (NODE_NONE where no edge).
// Latency: combinational.
// Backpressure: none.
// Ports: node_id in, nbrs out (index = direction). Ids >= 30 return no neighbours.
`timescale 1ns/1ps
module node_adjacency_rom
    import nav_pkg::*;
(
    input  node_id_t node_id,
    output nbr_set_t nbrs
);

    localparam node_id_t NA = NODE_NONE;

    always_comb begin
        nbrs = mk_nbrs(NA, NA, NA, NA);
        case (node_id)
            //                      north   east    south   west
            5'd0:  nbrs = mk_nbrs(5'd1,  NA,    5'd11, 5'd2);
            5'd1:  nbrs = mk_nbrs(NA,    5'd29, 5'd0,  5'd3);
            5'd2:  nbrs = mk_nbrs(5'd3,  5'd0,  5'd14, NA);
            5'd3:  nbrs = mk_nbrs(5'd4,  5'd1,  5'd2,  NA);
            5'd4:  nbrs = mk_nbrs(5'd5,  NA,    5'd3,  5'd17);
            5'd5:  nbrs = mk_nbrs(NA,    5'd6,  5'd4,  5'd18);
            5'd6:  nbrs = mk_nbrs(5'd24, 5'd7,  NA,    5'd5);
            5'd7:  nbrs = mk_nbrs(5'd25, NA,    5'd8,  5'd6);
            5'd8:  nbrs = mk_nbrs(5'd7,  5'd27, 5'd9,  NA);
            5'd9:  nbrs = mk_nbrs(5'd8,  NA,    5'd10, NA);
            5'd10: nbrs = mk_nbrs(5'd9,  NA,    5'd13, 5'd29);
            5'd11: nbrs = mk_nbrs(5'd0,  5'd12, NA,    5'd14);
            5'd12: nbrs = mk_nbrs(5'd22, 5'd13, NA,    5'd11);
            5'd13: nbrs = mk_nbrs(5'd10, NA,    NA,    5'd12);
            5'd14: nbrs = mk_nbrs(5'd2,  5'd11, NA,    5'd15);
            5'd15: nbrs = mk_nbrs(5'd16, 5'd14, NA,    NA);
            5'd16: nbrs = mk_nbrs(5'd17, NA,    5'd15, NA);
            5'd17: nbrs = mk_nbrs(5'd18, 5'd4,  5'd16, NA);
            5'd18: nbrs = mk_nbrs(5'd19, 5'd5,  5'd17, NA);
            5'd19: nbrs = mk_nbrs(NA,    5'd23, 5'd18, NA);
            5'd20: nbrs = mk_nbrs(5'd28, NA,    5'd29, 5'd21);
            5'd21: nbrs = mk_nbrs(NA,    5'd20, 5'd22, NA);
            5'd22: nbrs = mk_nbrs(5'd21, NA,    5'd12, NA);
            5'd23: nbrs = mk_nbrs(NA,    5'd24, NA,    5'd19);
            5'd24: nbrs = mk_nbrs(NA,    5'd25, 5'd6,  5'd23);
            5'd25: nbrs = mk_nbrs(NA,    5'd26, 5'd7,  5'd24);
            5'd26: nbrs = mk_nbrs(NA,    NA,    5'd27, 5'd25);
            5'd27: nbrs = mk_nbrs(5'd26, NA,    5'd28, 5'd8);
            5'd28: nbrs = mk_nbrs(5'd27, NA,    5'd20, NA);
            5'd29: nbrs = mk_nbrs(5'd20, 5'd10, NA,    5'd1);
            default: ;
        endcase
    end

endmodule

// File: rtl/path_sequencer.sv
// Purpose: buffers a planned node path, then issues one relative turn per leg and tracks position/heading.
// Latency: turn_valid 2..5 cycles after start/node_flag (one LOOKUP cycle per direction scanned, N,E,S,W).
// Backpressure: path_ready only in IDLE/LOAD with buffer space; start/node_flag ignored outside their states.
// Ports: clk_3125KHz, rst_n (async, active-low), bus (path_sequencer_if.slave).
`timescale 1ns/1ps
module path_sequencer
    import nav_pkg::*;
#(
    parameter int         NODE_W       = 5,
    parameter int         MAX_PATH     = 32,
    parameter int         IDX_W        = 5,
    parameter logic [1:0] INIT_HEADING = 2'd0
) (
    input logic             clk_3125KHz,
    input logic             rst_n,
    path_sequencer_if.slave bus
);

    localparam int LEN_W = IDX_W + 1;   // len counts 0..MAX_PATH inclusive

    seq_state_t        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, len_m1, idx_inc;
    logic [IDX_W-1:0]  idx_q;
    dir_t              dir_q, next_dir_q, heading_q;
    turn_t             turn_flag_q;
    logic              turn_valid_q, path_ready_q, path_ready_d;
    logic [NODE_W-1:0] pos_q, cur_node, nxt_node;
    logic [NODE_W-1:0] path_buf [MAX_PATH];
    nbr_set_t          nbrs;
    logic              xfer, match;
    logic              load_we, trav_init, dir_step, turn_fire, turn_commit, leg_adv;

    assign xfer     = bus.path_valid && path_ready_q;
    assign idx_inc  = {1'b0, idx_q} + LEN_W'(1);
    assign len_m1   = len_q - LEN_W'(1);
    assign cur_node = path_buf[idx_q];
    assign nxt_node = path_buf[idx_inc[IDX_W-1:0]];

    node_adjacency_rom u_rom (
        .node_id (node_id_t'(cur_node)),
        .nbrs    (nbrs)
    );

    // An out-of-range next node must never match, otherwise NODE_NONE
    // entries would pair up with a path entry of 31.
    assign match = (nbrs[dir_q] == node_id_t'(nxt_node)) &&
                   (node_id_t'(nxt_node) < NUM_NODES);

    always_comb begin
        state_d     = state_q;
        load_we     = 1'b0;
        trav_init   = 1'b0;
        dir_step    = 1'b0;
        turn_fire   = 1'b0;
        turn_commit = 1'b0;
        leg_adv     = 1'b0;
        if (bus.clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (xfer) begin
                        load_we = 1'b1;
                        if (bus.path_last)
                            state_d = S_WAIT_START;
                        else if (len_q == LEN_W'(MAX_PATH - 1))
                            state_d = S_ERROR;
                        else
                            state_d = S_LOAD;
                    end
                end
                S_WAIT_START: begin
                    if (bus.start) begin
                        trav_init = 1'b1;
                        state_d   = (len_q == LEN_W'(1)) ? S_DONE : S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (match) begin
                        turn_fire = 1'b1;
                        state_d   = S_TURN_OUT;
                    end else if (dir_q == DIR_W) begin
                        state_d = S_ERROR;
                    end else begin
                        dir_step = 1'b1;
                    end
                end
                S_TURN_OUT: begin
                    turn_commit = 1'b1;
                    state_d     = S_WAIT_NODE;
                end
                S_WAIT_NODE: begin
                    if (bus.node_flag) begin
                        leg_adv = 1'b1;
                        state_d = (idx_inc == len_m1) ? S_DONE : S_LOOKUP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        len_d = len_q;
        if (bus.clear)
            len_d = '0;
        else if (load_we)
            len_d = len_q + LEN_W'(1);
    end

    // Registered so that it stays low for the first cycle out of reset.
    assign path_ready_d = ((state_d == S_IDLE) || (state_d == S_LOAD)) &&
                          (len_d < LEN_W'(MAX_PATH));

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_3125KHz) begin
        if (load_we)
            path_buf[len_q[IDX_W-1:0]] <= bus.path_node;
    end

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            len_q        <= '0;
            idx_q        <= '0;
            dir_q        <= DIR_N;
            next_dir_q   <= DIR_N;
            heading_q    <= dir_t'(INIT_HEADING);
            turn_flag_q  <= TURN_STRAIGHT;
            turn_valid_q <= 1'b0;
            path_ready_q <= 1'b0;
            pos_q        <= '0;
        end else begin
            len_q        <= len_d;
            path_ready_q <= path_ready_d;
            turn_valid_q <= turn_fire;
            if (trav_init) begin
                idx_q     <= '0;
                dir_q     <= DIR_N;
                pos_q     <= path_buf[0];
                heading_q <= dir_t'(INIT_HEADING);
            end
            if (dir_step)
                dir_q <= dir_t'(2'(dir_q) + 2'd1);
            if (turn_fire) begin
                turn_flag_q <= rel_turn(dir_q, heading_q);
                next_dir_q  <= dir_q;
            end
            // Heading follows the turn one cycle later, after turn_flag was formed.
            if (turn_commit)
                heading_q <= next_dir_q;
            if (leg_adv) begin
                idx_q <= idx_inc[IDX_W-1:0];
                dir_q <= DIR_N;
                pos_q <= nxt_node;
            end
        end
    end

    assign bus.path_ready   = path_ready_q;
    assign bus.turn_flag    = turn_flag_q;
    assign bus.turn_valid   = turn_valid_q;
    assign bus.realtime_pos = pos_q;
    assign bus.heading      = heading_q;
    assign bus.busy         = (state_q == S_LOOKUP) || (state_q == S_TURN_OUT) ||
                              (state_q == S_WAIT_NODE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.error        = (state_q == S_ERROR);

endmodule

// File: tb/tb_path_sequencer.sv
// Purpose: randomized path loads and traversals checked against an edge-list arena model.
// Latency: turn cycle expected at reference edge + 1 + matched direction.
// Backpressure: loader waits on path_ready with a bounded budget.
`timescale 1ns/1ps
module tb_path_sequencer;

    localparam int         NW     = 5;
    localparam logic [1:0] INIT_H = 2'd3;
    localparam int         NONE   = 31;

    logic clk_3125KHz;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    path_sequencer_if #(.NODE_W(NW)) bus ();

    path_sequencer #(
        .NODE_W       (NW),
        .MAX_PATH     (32),
        .IDX_W        (5),
        .INIT_HEADING (INIT_H)
    ) dut (
        .clk_3125KHz (clk_3125KHz),
        .rst_n       (rst_n),
        .bus         (bus)
    );

    initial clk_3125KHz = 1'b0;
    always #160 clk_3125KHz = ~clk_3125KHz;
    always @(posedge clk_3125KHz) cyc <= cyc + 1;

    // Arena as undirected edges {a, dir_from_a_to_b, b}; dirs 0=N 1=E 2=S 3=W.
    int edges [40][3] = '{
        '{0,0,1},  '{1,1,29}, '{29,0,20}, '{20,3,21}, '{21,2,22}, '{0,3,2},   '{2,0,3},   '{3,1,1},
        '{3,0,4},  '{4,0,5},  '{5,1,6},   '{6,1,7},   '{7,2,8},   '{8,2,9},   '{9,2,10},  '{10,3,29},
        '{0,2,11}, '{11,1,12},'{12,1,13}, '{13,0,10}, '{11,3,14}, '{14,0,2},  '{14,3,15}, '{15,0,16},
        '{16,0,17},'{17,1,4}, '{17,0,18}, '{18,1,5},  '{18,0,19}, '{19,1,23}, '{23,1,24}, '{24,2,6},
        '{24,1,25},'{25,2,7}, '{25,1,26}, '{26,2,27}, '{27,2,28}, '{28,2,20}, '{27,3,8},  '{22,2,12}
    };
    int adj [32][4];
    int cur_path [$];

    typedef struct { int flag; int cyc; } exp_t;
    exp_t exp_q [$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_3125KHz);
        #1;
    endtask

    function automatic void build_map();
        for (int n = 0; n < 32; n++)
            for (int d = 0; d < 4; d++)
                adj[n][d] = NONE;
        for (int i = 0; i < 40; i++) begin
            adj[edges[i][0]][edges[i][1]]           = edges[i][2];
            adj[edges[i][2]][(edges[i][1] + 2) % 4] = edges[i][0];
        end
    endfunction

    // Direction from a to b, or -1 if they are not neighbours (or either id is off-map).
    function automatic int find_dir(input int a, input int b);
        if (a >= 30 || b >= 30) return -1;
        for (int d = 0; d < 4; d++)
            if (adj[a][d] == b) return d;
        return -1;
    endfunction

    task automatic gen_walk(input int n, input bit corrupt);
        int cur;
        cur_path.delete();
        cur = $urandom_range(29);
        cur_path.push_back(cur);
        for (int i = 1; i < n; i++) begin
            int opts [$];
            for (int d = 0; d < 4; d++)
                if (adj[cur][d] != NONE) opts.push_back(adj[cur][d]);
            cur = opts[$urandom_range(opts.size() - 1)];
            cur_path.push_back(cur);
        end
        if (corrupt)
            cur_path[$urandom_range(n - 1)] = $urandom_range(31);
    endtask

    // Monitor: every turn_valid cycle must match the oldest expected turn.
    always @(negedge clk_3125KHz) begin
        if (rst_n && bus.turn_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_turn", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("turn_flag", bus.turn_flag, mon_e.flag);
                check("turn_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic load_path(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            bit acc = 1'b0;
            if ($urandom_range(3) == 0) begin
                // Idle gap with stray controls that must be ignored while loading.
                bus.start     = 1'($urandom_range(1));
                bus.node_flag = 1'($urandom_range(1));
                tick();
                bus.start     = 1'b0;
                bus.node_flag = 1'b0;
            end
            bus.path_valid = 1'b1;
            bus.path_node  = NW'(cur_path[i]);
            bus.path_last  = with_last && (i == n - 1);
            for (int w = 0; w < 8 && !acc; w++) begin
                acc = bus.path_ready;
                tick();
            end
            bus.path_valid = 1'b0;
            bus.path_last  = 1'b0;
            if (!acc) begin
                check("load_accept", 0, 1);
                return;
            end
        end
    endtask

    task automatic wait_sig(input bit want_err, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            seen = want_err ? bus.error : bus.turn_valid;
        end
    endtask

    // Load cur_path, traverse it, and check every observable against the model.
    task automatic run_path();
        int n = cur_path.size();
        int h = INIT_H;
        int t, d;
        bit seen;
        load_path(n, 1'b1);
        check("ws_ready", bus.path_ready, 0);
        check("ws_busy", bus.busy, 0);
        check("ws_error", bus.error, 0);
        bus.node_flag = 1'b1;
        tick();
        bus.node_flag = 1'b0;
        check("ws_ignore_node", bus.busy, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        t = cyc;
        check("start_pos", bus.realtime_pos, cur_path[0]);
        check("start_heading", bus.heading, INIT_H);
        check("start_busy", bus.busy, n > 1);
        for (int i = 0; i < n - 1; i++) begin
            d = find_dir(cur_path[i], cur_path[i + 1]);
            if (d < 0) begin
                wait_sig(1'b1, seen);
                check("error_seen", seen, 1);
                check("error_cycle", cyc, t + 4);
                check("error_busy", bus.busy, 0);
                check("error_done", bus.done, 0);
                pulse_clear();
                check("clear_error", bus.error, 0);
                check("clear_ready", bus.path_ready, 1);
                return;
            end
            exp_q.push_back('{flag: (d - h) & 3, cyc: t + 1 + d});
            h = d;
            wait_sig(1'b0, seen);
            if (!seen) begin
                check("turn_timeout", 0, 1);
                return;
            end
            tick();
            check("leg_heading", bus.heading, h);
            repeat ($urandom_range(2)) tick();
            bus.node_flag = 1'b1;
            tick();
            bus.node_flag = 1'b0;
            t = cyc;
            check("leg_pos", bus.realtime_pos, cur_path[i + 1]);
        end
        check("end_done", bus.done, 1);
        check("end_busy", bus.busy, 0);
        check("end_heading", bus.heading, h);
        pulse_clear();
        check("clear_done", bus.done, 0);
        check("clear_ready", bus.path_ready, 1);
    endtask

    // Bring a 3-node path into WAIT_NODE after its first turn.
    task automatic to_wait_node();
        bit seen;
        cur_path = '{1, 29, 20};
        load_path(3, 1'b1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_q.push_back('{flag: (1 - INIT_H) & 3, cyc: cyc + 2});
        wait_sig(1'b0, seen);
        check("wn_turn_seen", seen, 1);
        tick();
    endtask

    initial begin
        build_map();
        rst_n = 1'b0;
        bus.clear = 1'b0; bus.path_valid = 1'b0; bus.path_node = '0; bus.path_last = 1'b0;
        bus.start = 1'b0; bus.node_flag = 1'b0;
        repeat (3) tick();
        check("rst_ready", bus.path_ready, 0);
        check("rst_turn_valid", bus.turn_valid, 0);
        check("rst_turn_flag", bus.turn_flag, 0);
        check("rst_pos", bus.realtime_pos, 0);
        check("rst_heading", bus.heading, INIT_H);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", bus.path_ready, 1);

        cur_path = '{0, 1, 29, 20, 21, 22}; run_path();
        cur_path = '{0, 1};                 run_path();
        cur_path = '{20, 21, 22, 21};       run_path();
        cur_path = '{0, 5};                 run_path();
        cur_path = '{7};                    run_path();
        cur_path = '{3, 31};                run_path();

        // Overflow: 32 entries without last.
        gen_walk(32, 1'b0);
        load_path(32, 1'b0);
        check("ovf_error", bus.error, 1);
        check("ovf_ready", bus.path_ready, 0);
        bus.path_valid = 1'b1;
        repeat (3) tick();
        bus.path_valid = 1'b0;
        check("ovf_ready_hold", bus.path_ready, 0);
        check("ovf_error_hold", bus.error, 1);
        pulse_clear();
        check("ovf_clear_ready", bus.path_ready, 1);

        // Full-depth path terminated on the 32nd entry, then traversed.
        gen_walk(32, 1'b0);
        run_path();

        // Reset in WAIT_NODE with a node_flag during reset.
        to_wait_node();
        rst_n = 1'b0;
        #1;
        check("mid_rst_pos", bus.realtime_pos, 0);
        check("mid_rst_heading", bus.heading, INIT_H);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_ready", bus.path_ready, 0);
        bus.node_flag = 1'b1;
        tick();
        bus.node_flag = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", bus.path_ready, 1);
        check("post_rst_pos", bus.realtime_pos, 0);

        // clear together with node_flag: position/heading held, no advance.
        to_wait_node();
        bus.clear = 1'b1;
        bus.node_flag = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.node_flag = 1'b0;
        check("clr_pos_held", bus.realtime_pos, 1);
        check("clr_heading_held", bus.heading, 1);
        check("clr_busy", bus.busy, 0);
        check("clr_done", bus.done, 0);
        check("clr_turn_valid", bus.turn_valid, 0);
        check("clr_ready", bus.path_ready, 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("idle_ignores_start", bus.busy, 0);

        for (int r = 0; r < 40; r++) begin
            gen_walk($urandom_range(1, 9), $urandom_range(5) == 0);
            run_path();
        end

        repeat (4) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #30_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
